regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port (WE3/WA3/WD3) between two writeback requesters: A (ALU result) and B (load data).
- Each requester uses a valid/ready handshake. Grants are round-robin, and the port outputs are registered.
- After reset, a built-in init sequencer zeroes registers 1..31 before any requester is served, so the register file never holds X after reset.

Parameters:
- AW, 5, register address width; the register file has 2^AW entries.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state changes on the posedge.
- reset  in  1  synchronous, active-high reset.
- a_valid  in  1  requester A has a write pending.
- a_addr  in  AW  requester A destination register.
- a_data  in  DW  requester A write data.
- a_ready  out  1  requester A accepted this cycle.
- b_valid  in  1  requester B has a write pending.
- b_addr  in  AW  requester B destination register.
- b_data  in  DW  requester B write data.
- b_ready  out  1  requester B accepted this cycle.
- WE3  out  1  register-file write enable, registered.
- WA3  out  AW  register-file write address, registered.
- WD3  out  DW  register-file write data, registered.
- init_done  out  1  high once the init sweep has completed.

Behaviour:
- State machine: INIT and RUN. Reset forces INIT with init counter = 1.
- Reset values: WE3=0, WA3=0, WD3=0, init_done=0, last_grant=B (so A wins the first tie).
- INIT state:
  - Each cycle, the next registered outputs are WE3=1, WA3=counter, WD3=0, and the counter increments.
  - When the counter is 2^AW-1 (31 at default), that write is issued and the next state is RUN. The counter does not wrap.
  - Writes to registers 1..31 appear on the port on cycles 1..31 after reset deasserts. init_done rises together with the last init write.
  - a_ready and b_ready are held at 0 for the whole of INIT.
- RUN state, grant rules (ready signals are combinational from valid and last_grant):
  - Only a_valid high: a_ready=1.
  - Only b_valid high: b_ready=1.
  - Both high: grant goes to the requester that is not last_grant.
  - At most one ready is high per cycle.
  - A transfer occurs on x_valid && x_ready. last_grant updates to that requester at the posedge.
- Latency: an accepted request appears on WA3/WD3 with WE3=1 exactly one cycle after acceptance. No buffering; throughput is one write per cycle.
- Idle cycle (no transfer): next WE3=0. WA3/WD3 hold their previous values.
- Register-0 writes: the request is accepted (ready=1, last_grant updates) but the next WE3=0.
- A requester denied on a tie must hold its valid, addr and data stable until accepted. The arbiter guarantees acceptance within 2 cycles.
- Reset mid-operation, including mid-INIT: returns to INIT with counter=1 and restarts the full sweep. An accepted write that has not yet been issued is discarded.
- Registered outputs never assert WE3 for address 0.

Optional Feature:
- Macro: REGARB_FIXED_PRIO_EN.
- Defined: fixed priority, A always wins ties. last_grant is unused, and B can starve while a_valid stays high.
- Undefined: round-robin as specified above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset 1 cycle then release -> WE3=1 on 31 consecutive cycles with WA3=1..31 and WD3=0. init_done=1 from the cycle WA3=31. a_ready and b_ready are 0 throughout.
- RUN, a_valid only with a_addr=5, a_data=0xDEADBEEF -> a_ready=1. Next cycle WE3=1, WA3=5, WD3=0xDEADBEEF. Following idle cycle WE3=0.
- RUN, both valid for 4 cycles (A: addr 3 data 0x11; B: addr 4 data 0x22), requesters hold until accepted then present the same values again -> grants alternate A,B,A,B. The port shows WA3 3,4,3,4 one cycle later.
- RUN, b_valid with b_addr=0, b_data=0xFFFFFFFF -> b_ready=1. Next cycle WE3=0, and the next tie is granted to A.
- Assert reset during INIT when the counter is 10 -> the sweep restarts at WA3=1 and runs the full 31 writes.
- Build with REGARB_FIXED_PRIO_EN, both valid for 3 cycles -> a_ready=1 all 3 cycles and b_ready=0.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Shares the register-file write port (WE3/WA3/WD3) between two writeback
//   requesters: A (ALU result) and B (load data). Both use valid/ready.
//   After reset, an init sweep writes zero to registers 1..2^AW-1, and only
//   then are requesters served. All port outputs are registered. A request is
//   accepted in the cycle its ready is high and is issued on the port in the
//   next cycle. Register 0 is never written.
//
//   Build option: REGARB_FIXED_PRIO_EN
//     undefined : ties are broken round-robin (A wins the first tie after reset)
//     defined   : A always wins ties and B may starve while a_valid stays high
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   INIT  | zeroing sweep in progress; one write per cycle to init_cnt;
//         | both requesters are held off (ready low)
//   RUN   | normal arbitration; one accepted request per cycle

module regfile_wr_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic          WE3,
  output logic [AW-1:0] WA3,
  output logic [DW-1:0] WD3,
  output logic          init_done
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_REG = {AW{1'b1}};
  localparam logic [AW-1:0] ONE      = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ZERO     = {AW{1'b0}};

  state_t        state;
  logic [AW-1:0] init_cnt;

  logic          in_run;
  logic          a_xfer;
  logic          b_xfer;

  assign in_run = (state == RUN);

`ifdef REGARB_FIXED_PRIO_EN

  // Fixed priority: A wins every tie; B is served only when A is idle.
  always_comb begin
    a_ready = in_run && a_valid;
    b_ready = in_run && b_valid && !a_valid;
  end

`else

  // 1 = B received the most recent grant, so A wins the next tie.
  logic last_b;

  // Round-robin: on a tie the requester that did not win last time is served.
  always_comb begin
    a_ready = in_run && a_valid && (!b_valid || last_b);
    b_ready = in_run && b_valid && (!a_valid || !last_b);
  end

  // Remember the winner of every transfer, including register-0 writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_b <= 1'b1;
    end else if (a_xfer) begin
      last_b <= 1'b0;
    end else if (b_xfer) begin
      last_b <= 1'b1;
    end
  end

`endif

  assign a_xfer = a_valid && a_ready;
  assign b_xfer = b_valid && b_ready;

  // Sweep/arbitration state machine driving the registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      init_cnt  <= ONE;
      WE3       <= 1'b0;
      WA3       <= ZERO;
      WD3       <= {DW{1'b0}};
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          WE3 <= 1'b1;
          WA3 <= init_cnt;
          WD3 <= {DW{1'b0}};
          if (init_cnt == LAST_REG) begin
            // Last sweep write issues now; the counter is left parked.
            state     <= RUN;
            init_done <= 1'b1;
          end else begin
            init_cnt <= init_cnt + ONE;
          end
        end
        RUN: begin
          if (a_xfer) begin
            // Register 0 is accepted but silently dropped; port keeps old addr/data.
            WE3 <= (a_addr != ZERO);
            if (a_addr != ZERO) begin
              WA3 <= a_addr;
              WD3 <= a_data;
            end
          end else if (b_xfer) begin
            WE3 <= (b_addr != ZERO);
            if (b_addr != ZERO) begin
              WA3 <= b_addr;
              WD3 <= b_data;
            end
          end else begin
            WE3 <= 1'b0;
          end
        end
        default: begin
          state <= INIT;
          WE3   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
// Honors REGARB_FIXED_PRIO_EN in the model so either build can be checked.

module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        a_valid = 1'b0;
  logic [4:0]  a_addr = '0;
  logic [31:0] a_data = '0;
  logic        a_ready;
  logic        b_valid = 1'b0;
  logic [4:0]  b_addr = '0;
  logic [31:0] b_data = '0;
  logic        b_ready;
  logic        WE3;
  logic [4:0]  WA3;
  logic [31:0] WD3;
  logic        init_done;

  regfile_wr_arbiter #(.AW(5), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_valid   (a_valid),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .WE3       (WE3),
    .WA3       (WA3),
    .WD3       (WD3),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  bit          m_known  = 0;   // model valid only after the first reset
  bit          m_run    = 0;
  int          m_next   = 1;   // next register the sweep will zero
  bit          m_last_b = 1;   // B was served most recently
  bit          e_we     = 0;
  logic [4:0]  e_wa     = '0;
  logic [31:0] e_wd     = '0;
  bit          e_done   = 0;
  bit          e_port_known = 1;  // addr/data after a register-0 drop are not pinned down

  bit acc_a, acc_b;               // model's grants in the last cycle

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, check readies, take the edge, check the port.
  task automatic cycle(input bit rst,
                       input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit bv, input logic [4:0] ba, input logic [31:0] bd);
    bit ma, mb;
    reset   = rst;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
    ma = 0;
    mb = 0;
    if (m_known && m_run) begin
`ifdef REGARB_FIXED_PRIO_EN
      ma = av;
      mb = bv && !av;
`else
      if (av && bv) begin
        ma = m_last_b;
        mb = !m_last_b;
      end else begin
        ma = av;
        mb = bv;
      end
`endif
    end
    if (m_known) begin
      chk("a_ready", 32'(a_ready), 32'(ma));
      chk("b_ready", 32'(b_ready), 32'(mb));
    end
    acc_a = ma;
    acc_b = mb;
    @(posedge clk);
    if (rst) begin
      m_known = 1; m_run = 0; m_next = 1; m_last_b = 1;
      e_we = 0; e_wa = '0; e_wd = '0; e_done = 0; e_port_known = 1;
    end else if (m_known) begin
      if (!m_run) begin
        e_we = 1; e_wa = 5'(m_next); e_wd = '0; e_port_known = 1;
        if (m_next == 31) begin
          m_run  = 1;
          e_done = 1;
        end else begin
          m_next++;
        end
      end else if (ma || mb) begin
        logic [4:0]  wa;
        logic [31:0] wd;
        wa = ma ? aa : ba;
        wd = ma ? ad : bd;
        m_last_b = mb;
        if (wa == 0) begin
          e_we = 0;
          e_port_known = 0;
        end else begin
          e_we = 1; e_wa = wa; e_wd = wd; e_port_known = 1;
        end
      end else begin
        e_we = 0;
      end
    end
    #1;
    if (m_known) begin
      chk("WE3", 32'(WE3), 32'(e_we));
      chk("init_done", 32'(init_done), 32'(e_done));
      if (e_port_known) begin
        chk("WA3", 32'(WA3), 32'(e_wa));
        chk("WD3", 32'(WD3), e_wd);
      end
    end
  endtask

  initial begin
    bit          ah, bh;
    bit          av, bv;
    logic [4:0]  aa, ba;
    logic [31:0] ad, bd;

    // reset for one cycle, then init sweep with both requesters knocking
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 31; i++) cycle(0, 1, 5'd7, 32'h77, 1, 5'd8, 32'h88);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // tie for 4 cycles: alternation A,B,A,B
    for (int i = 0; i < 4; i++) cycle(0, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // single A write, then idle
    cycle(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // B writes register 0: accepted, dropped, next tie goes to A
    cycle(0, 0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
    cycle(0, 1, 5'd9, 32'h99, 1, 5'd10, 32'hAA);
    cycle(0, 0, 0, 0, 1, 5'd10, 32'hAA);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // reset in the middle of the sweep (counter at 10), full sweep again
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 33; i++) cycle(0, 0, 0, 0, 0, 0, 0);

    // randomized traffic; denied requesters hold their request
    ah = 0; bh = 0;
    av = 0; bv = 0; aa = '0; ba = '0; ad = '0; bd = '0;
    for (int i = 0; i < 3000; i++) begin
      bit rst;
      rst = ($urandom_range(0, 299) == 0);
      if (!ah) begin
        av = ($urandom_range(0, 3) != 0);
        aa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        ad = $urandom;
      end
      if (!bh) begin
        bv = ($urandom_range(0, 3) != 0);
        ba = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        bd = $urandom;
      end
      cycle(rst, av, aa, ad, bv, ba, bd);
      ah = av && !acc_a && !rst;
      bh = bv && !acc_b && !rst;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
